// File: rtl/uart_tx_mmio_if.sv
// Store-path strobe/data from the I/O address decode plus the status lines that
// software polls through the load mux, bundled between CPU glue and the UART.
interface uart_tx_mmio_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             clr_ovf;
    logic             txd;
    logic             busy;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  txd, busy, empty, full, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output txd, busy, empty, full, level, overflow
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a small FIFO and a
// baud-timed FSM serialises them LSB first onto txd, back-to-back when queued.
module uart_tx_mmio #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int LVL_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_txd;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_baud_done;
    logic             w_txd_next;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_FULL);
    assign w_baud_done = (r_baud_cnt == BAUD_LAST);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push = bus.wr_en && (!w_full || w_pop);
    assign w_drop = bus.wr_en && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_txd_next   = 1'b0;
                end
            end
            S_START: begin
                w_txd_next = 1'b0;
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                    w_txd_next   = r_shift[0];
                end
            end
            S_DATA: begin
                w_txd_next = r_shift[0];
                if (w_baud_done) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_txd_next   = 1'b1;
                    end else begin
                        w_txd_next = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_txd_next   = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txd      <= 1'b1;
            r_shift    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_txd <= w_txd_next;
            if (w_pop) begin
                r_shift    <= r_mem[r_rptr];
                r_baud_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + 1'b1;
                if (w_baud_done && r_state == S_START) begin
                    r_bit_idx <= '0;
                end else if (w_baud_done && r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end
        end
    end

    // NOTE: storage is not reset; reset empties the FIFO through pointers and level alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.txd      = r_txd;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
endmodule
